// File: rtl/div_iter_if.sv
// Handshake/data bundle between the execute stage and the iterative divider.
// The pipeline side drives operands and the start strobe; the divider returns
// the quotient, the divide-by-zero flag and a one-cycle ready pulse.
interface div_iter_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output data_operandA,
        output data_operandB,
        output ctrl_DIV,
        input  data_result,
        input  data_exception,
        input  data_resultRDY
    );

    modport slave (
        input  data_operandA,
        input  data_operandB,
        input  ctrl_DIV,
        output data_result,
        output data_exception,
        output data_resultRDY
    );
endinterface

// File: rtl/div_iter.sv
// Iterative 32-bit signed divider, restoring algorithm, fixed 32-iteration
// latency. Magnitudes are divided and the sign is applied on completion.
// A start strobe in any state (re)launches a division; a divisor of zero runs
// the full iteration count and reports quotient 0 with the exception flag set.
module div_iter (
    input  logic      clock,
    input  logic      reset,
    div_iter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [4:0]  cnt;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic        sign;
    logic        zero;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [33:0] shifted;
    logic [33:0] trial;
    logic        fit;
    logic [31:0] quo_next;
    logic        last_iter;

    // Next-state selection; a start strobe overrides whatever is in progress.
    always_comb begin
        state_d   = state_q;
        last_iter = (state_q == RUN) && (cnt == 5'd31);
        if (bus.ctrl_DIV) begin
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                RUN:     if (cnt == 5'd31) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Operand magnitudes and one restoring step on {rem, quo} shifted left.
    // The trial is kept one bit wider than the remainder so its sign is explicit;
    // the result is identical to a 33-bit trial since rem < divisor.
    always_comb begin
        a_mag    = bus.data_operandA[31] ? (32'd0 - bus.data_operandA) : bus.data_operandA;
        b_mag    = bus.data_operandB[31] ? (32'd0 - bus.data_operandB) : bus.data_operandB;
        shifted  = {rem, quo[31]};
        trial    = shifted - {2'b00, dvs};
        fit      = ~trial[33];
        quo_next = {quo[30:0], fit};
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Datapath: operand capture, iteration, and registered result/flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt                <= '0;
            rem                <= '0;
            quo                <= '0;
            dvs                <= '0;
            sign               <= 1'b0;
            zero               <= 1'b0;
            bus.data_result    <= '0;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b0;
        end else if (bus.ctrl_DIV) begin
            cnt                <= '0;
            rem                <= '0;
            quo                <= a_mag;
            dvs                <= b_mag;
            sign               <= bus.data_operandA[31] ^ bus.data_operandB[31];
            zero               <= (bus.data_operandB == '0);
            bus.data_resultRDY <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    rem <= fit ? trial[32:0] : shifted[32:0];
                    quo <= quo_next;
                    cnt <= cnt + 5'd1;
                    if (last_iter) begin
                        bus.data_result    <= zero ? '0 : (sign ? (32'd0 - quo_next) : quo_next);
                        bus.data_exception <= zero;
                        bus.data_resultRDY <= 1'b1;
                    end
                end
                DONE:    bus.data_resultRDY <= 1'b0;
                default: bus.data_resultRDY <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: the stimulus pushes hand-computed expected
// results with their due cycle; a negedge monitor pops and compares on every
// ready pulse and checks that outputs hold between completions.
module tb_div_iter;
    logic clock;
    logic reset;
    div_iter_if bus ();

    div_iter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int unsigned checks;
    int unsigned errors;
    logic [31:0] hold_res;
    logic        hold_exc;
    logic        prev_rdy;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_edges(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Assumes the caller is just past a rising edge; the strobe is sampled at
    // the next edge, after which the operands are scrambled.
    task automatic do_start(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] r, input logic x, input bit push);
        exp_t e;
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        if (push) begin
            e.res = r;
            e.exc = x;
            e.cyc = cyc + 32;
            sb.push_back(e);
        end
    endtask

    // Monitor: compare completions against the scoreboard and check hold behaviour.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            hold_res = '0;
            hold_exc = 1'b0;
            prev_rdy = 1'b0;
        end else begin
            if (prev_rdy) check("rdy_pulse_width", {31'd0, bus.data_resultRDY}, 32'd0);
            if (bus.data_resultRDY) begin
                if (sb.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", bus.data_result, e.res);
                    check("exception", {31'd0, bus.data_exception}, {31'd0, e.exc});
                    check("latency_cycle", cyc, e.cyc);
                    hold_res = e.res;
                    hold_exc = e.exc;
                end
            end else begin
                check("result_hold", bus.data_result, hold_res);
                check("exception_hold", {31'd0, bus.data_exception}, {31'd0, hold_exc});
            end
            prev_rdy = bus.data_resultRDY;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        cyc               = 0;
        checks            = 0;
        errors            = 0;
        hold_res          = '0;
        hold_exc          = 1'b0;
        prev_rdy          = 1'b0;
        reset             = 1'b1;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        wait_edges(3);
        check("reset_result", bus.data_result, 32'd0);
        check("reset_exception", {31'd0, bus.data_exception}, 32'd0);
        check("reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        reset = 1'b0;
        wait_edges(2);

        // Sign combinations, divide by zero, extremes.
        do_start(32'd100, 32'd7, 32'd14, 1'b0, 1);               wait_edges(34);
        do_start(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b0, 1);    wait_edges(34);
        do_start(32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 1);  wait_edges(34);
        do_start(32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 1'b0, 1);   wait_edges(34);
        do_start(32'd5, 32'd0, 32'd0, 1'b1, 1);                  wait_edges(34);
        do_start(32'd6, 32'd3, 32'd2, 1'b0, 1);                  wait_edges(34);
        do_start(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1); wait_edges(34);
        do_start(32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 1'b0, 1);    wait_edges(34);
        do_start(32'd7, 32'd100, 32'd0, 1'b0, 1);                wait_edges(34);

        // Restart mid-run: only the second division completes.
        do_start(32'd100, 32'd7, 32'd14, 1'b0, 0);
        wait_edges(9);
        do_start(32'd9, 32'd3, 32'd3, 1'b0, 1);                  wait_edges(34);

        // Back-to-back: second start lands on the DONE edge.
        do_start(32'd20, 32'd4, 32'd5, 1'b0, 1);
        wait_edges(32);
        do_start(32'hFFFFFFF7, 32'd2, 32'hFFFFFFFC, 1'b0, 1);    wait_edges(34);

        // Asynchronous reset mid-division.
        do_start(32'd100, 32'd7, 32'd14, 1'b0, 0);
        wait_edges(14);
        reset = 1'b1;
        #1;
        check("async_reset_result", bus.data_result, 32'd0);
        check("async_reset_exception", {31'd0, bus.data_exception}, 32'd0);
        check("async_reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        wait_edges(2);
        reset = 1'b0;
        wait_edges(40);
        do_start(32'd8, 32'd2, 32'd4, 1'b0, 1);                  wait_edges(40);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
